// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared forwarding codes, Tuse sentinel and mult/div FSM states.
package pipe_ctrl_pkg;
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E = 2'd1;
  localparam logic [1:0] FWD_M = 2'd2;
  // E-stage muxes sit one stage later, so M ALUout and W data take codes 01/10
  localparam logic [1:0] FWD_ME = 2'd1;
  localparam logic [1:0] FWD_W = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;
  function automatic logic data_haz(input logic [4:0] a, input logic [1:0] tuse,
                                    input logic [4:0] wa, input logic [1:0] tnew);
    return a != 5'd0 && tuse != TUSE_NONE && a == wa && tnew > tuse;
  endfunction
  function automatic logic [1:0] fwd_pick(input logic [4:0] a,
                                          input logic [4:0] near_wa, input logic near_rdy, input logic [1:0] near_code,
                                          input logic [4:0] far_wa, input logic far_rdy, input logic [1:0] far_code);
    return a == 5'd0 ? FWD_RF :
           (a == near_wa && near_rdy) ? near_code :
           (a == far_wa && far_rdy) ? far_code : FWD_RF;
  endfunction
endpackage

// File: rtl/md_busy_ctr.sv
// md_busy_ctr: mult/div occupancy FSM with a reloadable down-counter; owns md_busy.
module md_busy_ctr
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic is_div_i,
  output logic md_busy_o
);
  md_state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic busy_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      state_q <= MD_BUSY;
      cnt_q <= is_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      busy_q <= 1'b1;
    end else if (state_q == MD_BUSY) begin
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        state_q <= MD_IDLE;
        busy_q <= 1'b0;
      end
    end
  end
  assign md_busy_o = busy_q;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline stall/flush and forwarding control with mult/div sequencing.
// Define HAZ_PERF_CNT_EN to build the saturating stall-cycle counter on stall_cnt.
module hazard_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_rs,
  input  logic [4:0]  E_rt,
  input  logic [4:0]  E_waddr,
  input  logic [1:0]  E_Tnew,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  input  logic [4:0]  M_rt,
  input  logic [4:0]  M_waddr,
  input  logic [1:0]  M_Tnew,
  input  logic [4:0]  W_waddr,
  output logic        stall,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_clr,
  output logic [1:0]  fwd_D_rs,
  output logic [1:0]  fwd_D_rt,
  output logic [1:0]  fwd_E_rs,
  output logic [1:0]  fwd_E_rt,
  output logic        fwd_M_rt,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);
  logic data_stall, md_stall;
  md_busy_ctr #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) u_md (
    .clk(clk), .reset(reset), .start_i(E_md_start), .is_div_i(E_md_is_div), .md_busy_o(md_busy)
  );
  always_comb begin
    data_stall = data_haz(D_rs, D_Tuse_rs, E_waddr, E_Tnew) | data_haz(D_rs, D_Tuse_rs, M_waddr, M_Tnew) |
                 data_haz(D_rt, D_Tuse_rt, E_waddr, E_Tnew) | data_haz(D_rt, D_Tuse_rt, M_waddr, M_Tnew);
    md_stall = D_is_md & (E_md_start | md_busy);
    stall = data_stall | md_stall;
    pc_en = ~stall;
    if_id_en = ~stall;
    id_ex_clr = stall;
    fwd_D_rs = fwd_pick(D_rs, E_waddr, E_Tnew == 2'd0, FWD_E, M_waddr, M_Tnew == 2'd0, FWD_M);
    fwd_D_rt = fwd_pick(D_rt, E_waddr, E_Tnew == 2'd0, FWD_E, M_waddr, M_Tnew == 2'd0, FWD_M);
    fwd_E_rs = fwd_pick(E_rs, M_waddr, M_Tnew == 2'd0, FWD_ME, W_waddr, 1'b1, FWD_W);
    fwd_E_rt = fwd_pick(E_rt, M_waddr, M_Tnew == 2'd0, FWD_ME, W_waddr, 1'b1, FWD_W);
    fwd_M_rt = M_rt != 5'd0 && M_rt == W_waddr;
  end
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
  end
  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: vector table, directed mult/div sequences and random checks against a model.
module tb_hazard_ctrl_unit;
  logic clk = 1'b0, reset;
  logic [4:0] D_rs, D_rt, E_rs, E_rt, E_waddr, M_rt, M_waddr, W_waddr;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic D_is_md, E_md_start, E_md_is_div;
  logic stall, pc_en, if_id_en, id_ex_clr, fwd_M_rt, md_busy;
  logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;
  logic [31:0] stall_cnt;
  int checks = 0, failures = 0;
  int rem = 0;
  longint exp_cnt = 0;
  typedef struct {
    int d_rs, tu_rs, d_rt, tu_rt, e_rs, e_rt, e_wa, e_tn, m_rt, m_wa, m_tn, w_wa;
    int x_stall, x_fdrs, x_fdrt, x_fers, x_fert, x_fmrt;
  } vec_t;
  vec_t tbl[12];
  always #5 clk = ~clk;
  hazard_ctrl_unit dut (
    .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_is_md(D_is_md), .E_rs(E_rs), .E_rt(E_rt), .E_waddr(E_waddr), .E_Tnew(E_Tnew),
    .E_md_start(E_md_start), .E_md_is_div(E_md_is_div), .M_rt(M_rt), .M_waddr(M_waddr),
    .M_Tnew(M_Tnew), .W_waddr(W_waddr), .stall(stall), .pc_en(pc_en), .if_id_en(if_id_en),
    .id_ex_clr(id_ex_clr), .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt), .fwd_E_rs(fwd_E_rs),
    .fwd_E_rt(fwd_E_rt), .fwd_M_rt(fwd_M_rt), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );
  function automatic bit op_haz(int a, int tuse);
    if (a == 0 || tuse == 3) return 0;
    return (a == int'(E_waddr) && int'(E_Tnew) > tuse) || (a == int'(M_waddr) && int'(M_Tnew) > tuse);
  endfunction
  function automatic bit exp_stall();
    return op_haz(int'(D_rs), int'(D_Tuse_rs)) || op_haz(int'(D_rt), int'(D_Tuse_rt)) ||
           (D_is_md && (E_md_start || rem > 0));
  endfunction
  function automatic int exp_fd(int a);
    if (a != 0 && a == int'(E_waddr) && E_Tnew == 0) return 1;
    if (a != 0 && a == int'(M_waddr) && M_Tnew == 0) return 2;
    return 0;
  endfunction
  function automatic int exp_fe(int a);
    if (a != 0 && a == int'(M_waddr) && M_Tnew == 0) return 1;
    if (a != 0 && a == int'(W_waddr)) return 2;
    return 0;
  endfunction
  function automatic longint exp_stall_cnt();
`ifdef HAZ_PERF_CNT_EN
    return exp_cnt > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : exp_cnt;
`else
    return 0;
`endif
  endfunction
  always @(posedge clk) begin
    if (!reset && exp_stall()) exp_cnt++;
    if (reset) begin
      rem = 0;
      exp_cnt = 0;
    end else if (E_md_start) rem = E_md_is_div ? 10 : 5;
    else if (rem > 0) rem--;
  end
  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic zero();
    {D_rs, D_rt, E_rs, E_rt, E_waddr, M_rt, M_waddr, W_waddr} = '0;
    {D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew} = '0;
    {D_is_md, E_md_start, E_md_is_div} = '0;
  endtask
  task automatic chk_model(string tag);
    bit s;
    s = exp_stall();
    chk({tag, "_stall"}, stall, s);
    chk({tag, "_pc_en"}, pc_en, !s);
    chk({tag, "_if_id_en"}, if_id_en, !s);
    chk({tag, "_id_ex_clr"}, id_ex_clr, s);
    chk({tag, "_fwd_D_rs"}, fwd_D_rs, exp_fd(int'(D_rs)));
    chk({tag, "_fwd_D_rt"}, fwd_D_rt, exp_fd(int'(D_rt)));
    chk({tag, "_fwd_E_rs"}, fwd_E_rs, exp_fe(int'(E_rs)));
    chk({tag, "_fwd_E_rt"}, fwd_E_rt, exp_fe(int'(E_rt)));
    chk({tag, "_fwd_M_rt"}, fwd_M_rt, (M_rt != 0 && M_rt == W_waddr));
    chk({tag, "_md_busy"}, md_busy, rem > 0);
    chk({tag, "_stall_cnt"}, stall_cnt, exp_stall_cnt());
  endtask
  initial begin
    //        d_rs tu  d_rt tu  e_rs e_rt e_wa e_tn m_rt m_wa m_tn w_wa | stall fdrs fdrt fers fert fmrt
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    tbl[1]  = '{8, 0, 0, 0, 0, 0, 8, 2, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 9, 0, 0, 0, 0, 9, 0, 0,   0, 0, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 9, 0, 0, 0, 0, 9, 0, 9,   0, 0, 0, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 9, 0, 0, 9, 0, 0, 9,   0, 0, 0, 0, 2, 1};
    tbl[6]  = '{5, 1, 5, 1, 0, 0, 5, 0, 0, 5, 0, 0,   0, 1, 1, 0, 0, 0};
    tbl[7]  = '{0, 0, 7, 3, 0, 0, 7, 2, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 4, 1, 0, 0, 0, 0, 0, 4, 2, 0,   1, 0, 0, 0, 0, 0};
    tbl[9]  = '{4, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    tbl[10] = '{6, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0,   0, 2, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 3, 1, 3,   0, 0, 0, 2, 0, 0};
    zero();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_pc_en", pc_en, 1);
    chk("rst_if_id_en", if_id_en, 1);
    chk("rst_md_busy", md_busy, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_fwd", {fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt}, 0);
    foreach (tbl[i]) begin
      tick();
      D_rs = 5'(tbl[i].d_rs); D_Tuse_rs = 2'(tbl[i].tu_rs);
      D_rt = 5'(tbl[i].d_rt); D_Tuse_rt = 2'(tbl[i].tu_rt);
      E_rs = 5'(tbl[i].e_rs); E_rt = 5'(tbl[i].e_rt);
      E_waddr = 5'(tbl[i].e_wa); E_Tnew = 2'(tbl[i].e_tn);
      M_rt = 5'(tbl[i].m_rt); M_waddr = 5'(tbl[i].m_wa); M_Tnew = 2'(tbl[i].m_tn);
      W_waddr = 5'(tbl[i].w_wa);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), stall, tbl[i].x_stall);
      chk($sformatf("vec%0d_id_ex_clr", i), id_ex_clr, tbl[i].x_stall);
      chk($sformatf("vec%0d_fwd_D_rs", i), fwd_D_rs, tbl[i].x_fdrs);
      chk($sformatf("vec%0d_fwd_D_rt", i), fwd_D_rt, tbl[i].x_fdrt);
      chk($sformatf("vec%0d_fwd_E_rs", i), fwd_E_rs, tbl[i].x_fers);
      chk($sformatf("vec%0d_fwd_E_rt", i), fwd_E_rt, tbl[i].x_fert);
      chk($sformatf("vec%0d_fwd_M_rt", i), fwd_M_rt, tbl[i].x_fmrt);
    end
    // load-use: stall while the load sits in E and in M, then forward from M
    tick(); zero();
    E_waddr = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8;
    @(negedge clk);
    chk("lw_e_stall", stall, 1);
    chk("lw_e_pc_en", pc_en, 0);
    chk("lw_e_id_ex_clr", id_ex_clr, 1);
    tick();
    E_waddr = 5'd0; E_Tnew = 2'd0; M_waddr = 5'd8; M_Tnew = 2'd1;
    @(negedge clk);
    chk("lw_m_stall", stall, 1);
    tick();
    M_Tnew = 2'd0;
    @(negedge clk);
    chk("lw_done_stall", stall, 0);
    chk("lw_done_fwd_D_rs", fwd_D_rs, 2);
    // div occupies the unit for exactly 10 cycles
    tick(); zero();
    D_is_md = 1'b1; E_md_start = 1'b1; E_md_is_div = 1'b1;
    @(negedge clk);
    chk("div_issue_stall", stall, 1);
    chk("div_issue_busy", md_busy, 0);
    tick();
    E_md_start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk($sformatf("div_c%0d_busy", i), md_busy, i < 10);
      chk($sformatf("div_c%0d_stall", i), stall, i < 10);
      tick();
    end
    chk("div_stall_cnt", stall_cnt, exp_stall_cnt());
    // reset during the third busy cycle of a mult abandons it
    zero();
    D_is_md = 1'b1; E_md_start = 1'b1;
    tick();
    E_md_start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_busy_before", md_busy, 1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_busy_after", md_busy, 0);
    chk("mrst_stall_after", stall, 0);
    chk("mrst_stall_cnt", stall_cnt, 0);
    for (int i = 0; i < 400; i++) begin
      tick();
      D_rs = 5'($urandom_range(0, 3)); D_rt = 5'($urandom_range(0, 3));
      D_Tuse_rs = 2'($urandom_range(0, 3)); D_Tuse_rt = 2'($urandom_range(0, 3));
      D_is_md = 1'($urandom_range(0, 1));
      E_rs = 5'($urandom_range(0, 3)); E_rt = 5'($urandom_range(0, 3));
      E_waddr = 5'($urandom_range(0, 3)); E_Tnew = 2'($urandom_range(0, 2));
      E_md_start = ($urandom_range(0, 11) == 0); E_md_is_div = 1'($urandom_range(0, 1));
      M_rt = 5'($urandom_range(0, 3)); M_waddr = 5'($urandom_range(0, 3));
      M_Tnew = 2'($urandom_range(0, 1)); W_waddr = 5'($urandom_range(0, 3));
      reset = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      chk_model($sformatf("rnd%0d", i));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
